// File: rtl/logic_reduce_unit_if.sv
// Operand/result handshake bundle for logic_reduce_unit.
// The DUT side uses the slave modport; the operand source and result sink use master.
interface logic_reduce_unit_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_bad_op;

  modport slave (
    input  op, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf, out_bad_op
  );

  modport master (
    output op, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf, out_bad_op
  );
endinterface

// File: rtl/logic_reduce_unit.sv
// Streaming bitwise reducer (AND/OR/XOR and inverted forms) with valid/ready on both sides.
// Define LOGIC_REDUCE_BACK2BACK_EN to let a new transaction start in the result-handshake cycle.
module logic_reduce_unit #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input logic                clk,
  input logic                rst_n,
  logic_reduce_unit_if.slave lr_if
);

  localparam int               CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_OUT
  } state_e;

  state_e           state_q, state_d;
  logic             run_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_bad_op_q, out_bad_op_d;

  logic in_ready;
  logic out_valid;
  logic beat_acc;
  logic res_acc;
  logic first_beat;

  // Base operation shared by a plain op and its inverted twin; reserved ops
  // still fold beats (result is forced to zero at the output instead).
  function automatic logic [WIDTH-1:0] combine(input logic [2:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'd0, 3'd3: combine = a & b;
      3'd1, 3'd4: combine = a | b;
      default:    combine = a ^ b;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] finalize(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a);
    case (op)
      3'd0, 3'd1, 3'd2: finalize = a;
      3'd3, 3'd4, 3'd5: finalize = ~a;
      default:          finalize = '0;
    endcase
  endfunction

  // run_q holds in_ready low through reset and for no longer than one edge after it.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACC: in_ready = run_q;
      ST_OUT: begin
`ifdef LOGIC_REDUCE_BACK2BACK_EN
        in_ready = lr_if.out_ready;
`else
        in_ready = 1'b0;
`endif
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign out_valid  = (state_q == ST_OUT);
  assign beat_acc   = lr_if.in_valid & in_ready;
  assign res_acc    = out_valid & lr_if.out_ready;
  assign first_beat = (state_q != ST_ACC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (beat_acc) state_d = lr_if.in_last ? ST_OUT : ST_ACC;
      end
      ST_ACC: begin
        if (beat_acc && lr_if.in_last) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (res_acc) begin
          state_d = ST_IDLE;
`ifdef LOGIC_REDUCE_BACK2BACK_EN
          if (beat_acc) state_d = lr_if.in_last ? ST_OUT : ST_ACC;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Inputs are only looked at under beat_acc, so X on idle inputs never reaches state.
  always_comb begin
    acc_d        = acc_q;
    op_d         = op_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_ovf_d    = out_ovf_q;
    out_bad_op_d = out_bad_op_q;
    if (beat_acc) begin
      if (first_beat) begin
        acc_d   = lr_if.in_data;
        op_d    = lr_if.op;
        count_d = CNT_ONE;
        ovf_d   = 1'b0;
      end else begin
        acc_d   = combine(op_q, acc_q, lr_if.in_data);
        count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_ONE;
        ovf_d   = ovf_q | (count_q == CNT_MAX);
      end
      if (lr_if.in_last) begin
        out_data_d   = finalize(op_d, acc_d);
        out_count_d  = count_d;
        out_ovf_d    = ovf_d;
        out_bad_op_d = op_d[2] & op_d[1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= ST_IDLE;
      run_q        <= 1'b0;
      acc_q        <= '0;
      op_q         <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_ovf_q    <= 1'b0;
      out_bad_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= 1'b1;
      acc_q        <= acc_d;
      op_q         <= op_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_ovf_q    <= out_ovf_d;
      out_bad_op_q <= out_bad_op_d;
    end
  end

  assign lr_if.in_ready   = in_ready;
  assign lr_if.out_valid  = out_valid;
  assign lr_if.out_data   = out_data_q;
  assign lr_if.out_count  = out_count_q;
  assign lr_if.out_ovf    = out_ovf_q;
  assign lr_if.out_bad_op = out_bad_op_q;

endmodule
